// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
// Holds the FSM state encoding, port indices and default widths.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned NUM_PORTS  = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-hot strobe vector for a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    port_onehot = (port == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the pointer.
// Purely combinational; the pointer register is owned by the caller.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 valid_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = port_onehot(ptr_i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported 256x8 data RAM between the CPU LSU (port 0) and the
// DMA/debug loader (port 1), issuing 1..16-beat incrementing bursts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] we_i,
  input  logic [ADDR_W-1:0]    addr0_i,
  input  logic [ADDR_W-1:0]    addr1_i,
  input  logic [LEN_W-1:0]     len0_i,
  input  logic [LEN_W-1:0]     len1_i,
  input  logic [DATA_W-1:0]    wd0_i,
  input  logic [DATA_W-1:0]    wd1_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [NUM_PORTS-1:0] ack_o,
  output logic [NUM_PORTS-1:0] rvalid_o,
  output logic [DATA_W-1:0]    rd_o,
  output logic [NUM_PORTS-1:0] done_o,
  output logic [ADDR_W-1:0]    mem_a_o,
  output logic [DATA_W-1:0]    mem_wd_o,
  output logic                 mem_we_o,
  input  logic [DATA_W-1:0]    mem_rd_i
);

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 own_q, own_d;
  logic                 bwe_q, bwe_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_q, beat_d;

  logic [NUM_PORTS-1:0] gnt_d, ack_d, rvalid_d, done_d;
  logic [DATA_W-1:0]    rd_d;
  logic [ADDR_W-1:0]    mem_a_d;
  logic                 mem_we_d;

  logic [NUM_PORTS-1:0] win_gnt;
  logic                 win_valid;
  logic                 win_port;

  rr_arb2 u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .valid_o (win_valid)
  );

  assign win_port = win_gnt[1];

  // Write data is steered straight through from the owner; idle drives zero.
  assign mem_wd_o = (state_q == BURST) ? ((own_q == PORT_DMA) ? wd1_i : wd0_i)
                                       : '0;

  // Next-state and next-output decode; every output flop is fed from here.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    bwe_d    = bwe_q;
    len_d    = len_q;
    beat_d   = beat_q;
    gnt_d    = '0;
    ack_d    = '0;
    rvalid_d = '0;
    done_d   = '0;
    mem_we_d = 1'b0;
    mem_a_d  = mem_a_o;
    rd_d     = rd_o;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          own_d    = win_port;
          bwe_d    = (win_port == PORT_DMA) ? we_i[1] : we_i[0];
          len_d    = (win_port == PORT_DMA) ? len1_i : len0_i;
          beat_d   = '0;
          mem_a_d  = (win_port == PORT_DMA) ? addr1_i : addr0_i;
          mem_we_d = bwe_d;
          gnt_d    = win_gnt;
          ack_d    = win_gnt;
          state_d  = BURST;
        end
      end

      BURST: begin
        if (!bwe_q) begin
          rd_d     = mem_rd_i;
          rvalid_d = port_onehot(own_q);
        end
        if (beat_q == len_q) begin
          done_d  = port_onehot(own_q);
          state_d = DONE;
        end else begin
          // Address wraps naturally at ADDR_W bits.
          beat_d   = beat_q + LEN_W'(1);
          mem_a_d  = mem_a_o + ADDR_W'(1);
          mem_we_d = bwe_q;
          gnt_d    = port_onehot(own_q);
          ack_d    = port_onehot(own_q);
        end
      end

      DONE: begin
        ptr_d   = ~own_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= PORT_CPU;
      own_q    <= PORT_CPU;
      bwe_q    <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      gnt_o    <= '0;
      ack_o    <= '0;
      rvalid_o <= '0;
      done_o   <= '0;
      rd_o     <= '0;
      mem_a_o  <= '0;
      mem_we_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      bwe_q    <= bwe_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      gnt_o    <= gnt_d;
      ack_o    <= ack_d;
      rvalid_o <= rvalid_d;
      done_o   <= done_d;
      rd_o     <= rd_d;
      mem_a_o  <= mem_a_d;
      mem_we_o <= mem_we_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bench-side RAM, timeline model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0, we = '0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [3:0] len0 = '0, len1 = '0;
  logic [7:0] wd0 = '0, wd1 = '0;
  logic [1:0] gnt, ack, rvalid, done;
  logic [7:0] rd, mem_a, mem_wd, mem_rd;
  logic       mem_we;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .len0_i(len0), .len1_i(len1),
    .wd0_i(wd0), .wd1_i(wd1), .gnt_o(gnt), .ack_o(ack), .rvalid_o(rvalid),
    .rd_o(rd), .done_o(done), .mem_a_o(mem_a), .mem_wd_o(mem_wd),
    .mem_we_o(mem_we), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : (8'(i) ^ 8'h5A);
  endfunction

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Environment RAM: combinational read, synchronous write.
  logic [7:0] ram [256];
  logic       ram_load = 1'b1;
  assign mem_rd = ram[mem_a];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_a] <= mem_wd;
    end
  end

  // Timeline model: a burst granted in idle cycle s-1 owns cycles s..s+len,
  // read data follows one cycle later, done lands on s+len+1.
  logic [7:0] shadow [256];
  logic       m_act = 1'b0, m_ptr = 1'b0, m_own = 1'b0, m_we = 1'b0;
  int         m_s = 0, m_len = 0, m_base = 0, k = 0;
  logic [7:0] m_last_a = '0, m_rd = '0;
  logic [1:0] e_gnt, e_ack, e_rv, e_done;
  logic [7:0] e_a, e_wd, e_rd;
  logic       e_we, in_beat;

  always @(negedge clk) begin
    if (ram_load) for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    e_gnt = '0; e_ack = '0; e_rv = '0; e_done = '0;
    e_we = 1'b0; e_wd = '0; e_a = m_last_a; e_rd = m_rd;
    in_beat = 1'b0; k = -1;
    if (!rst) begin
      m_act = 1'b0; m_ptr = 1'b0; m_last_a = '0; m_rd = '0;
      e_a = '0; e_rd = '0;
    end else if (m_act) begin
      k = cyc - m_s;
      if (k >= 0 && k <= m_len) begin
        in_beat = 1'b1;
        e_gnt = oh(m_own); e_ack = oh(m_own);
        e_a = 8'(m_base + k);
        e_we = m_we;
        e_wd = m_own ? wd1 : wd0;
      end
      if (!m_we && k >= 1 && k <= m_len + 1) begin
        e_rv = oh(m_own);
        e_rd = shadow[8'(m_base + k - 1)];
      end
      if (k == m_len + 1) e_done = oh(m_own);
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("done", 32'(done), 32'(e_done));
    chk("mem_a", 32'(mem_a), 32'(e_a));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_wd", 32'(mem_wd), 32'(e_wd));
    chk("rd", 32'(rd), 32'(e_rd));
    if (rst) begin
      m_last_a = e_a;
      m_rd = e_rd;
      if (in_beat && m_we) shadow[e_a] = e_wd;
      if (m_act && k == m_len + 1) m_ptr = !m_own;
      if ((!m_act || k >= m_len + 2) && req != 2'b00) begin
        m_own  = (req == 2'b11) ? m_ptr : req[1];
        m_we   = we[m_own];
        m_base = m_own ? int'(addr1) : int'(addr0);
        m_len  = m_own ? int'(len1) : int'(len0);
        m_s    = cyc + 1;
        m_act  = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] alt_exp [13] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                               2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
  int         n_ack, n_rv, n_done;
  logic [7:0] got [3];

  initial begin
    // Reset state
    tick; tick;
    ram_load = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_rd", 32'(rd), 32'h0);
    tick;
    rst = 1'b1;

    // Port 0 single read of 0x10
    req = 2'b01; we = 2'b00; addr0 = 8'h10; len0 = 4'd0;
    @(negedge clk); chk("t1_idle_gnt", 32'(gnt), 32'h0);
    tick; req = 2'b00;
    @(negedge clk);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_mem_a", 32'(mem_a), 32'h10);
    tick;
    @(negedge clk);
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rd", 32'(rd), 32'hA5);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_gnt_low", 32'(gnt), 32'h0);
    tick;

    // Port 1 wrapping write burst, port 0 data is noise
    req = 2'b10; we = 2'b10; addr1 = 8'hFE; len1 = 4'd3; wd1 = 8'h11; wd0 = 8'hEE;
    tick; req = 2'b00;
    @(negedge clk);
    chk("t2_a0", 32'(mem_a), 32'hFE); chk("t2_we0", 32'(mem_we), 32'h1);
    chk("t2_wd0", 32'(mem_wd), 32'h11); chk("t2_gnt", 32'(gnt), 32'h2);
    tick; wd1 = 8'h22; @(negedge clk); chk("t2_a1", 32'(mem_a), 32'hFF);
    tick; wd1 = 8'h33; @(negedge clk); chk("t2_a2", 32'(mem_a), 32'h00);
    tick; wd1 = 8'h44; @(negedge clk); chk("t2_a3", 32'(mem_a), 32'h01);
    chk("t2_we3", 32'(mem_we), 32'h1);
    tick; @(negedge clk);
    chk("t2_done", 32'(done), 32'h2); chk("t2_we_off", 32'(mem_we), 32'h0);
    tick;
    chk("t2_ram_fe", 32'(ram[8'hFE]), 32'h11);
    chk("t2_ram_ff", 32'(ram[8'hFF]), 32'h22);
    chk("t2_ram_00", 32'(ram[8'h00]), 32'h33);
    chk("t2_ram_01", 32'(ram[8'h01]), 32'h44);

    // Both requesting from reset: alternate with one idle cycle between
    rst = 1'b0; tick; tick;
    rst = 1'b1; req = 2'b11; we = 2'b00;
    addr0 = 8'h20; len0 = 4'd1; addr1 = 8'h30; len1 = 4'd0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("t3_alt_gnt", 32'(gnt), 32'(alt_exp[i]));
    end
    tick; req = 2'b00;
    tick; tick;

    // Port 1 arrives mid-burst and waits for the next idle cycle
    req = 2'b01; addr0 = 8'h50; len0 = 4'd5;
    tick; req = 2'b00;
    tick; req = 2'b10; addr1 = 8'h60; len1 = 4'd0;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      chk("t4_no_gnt1", 32'(gnt[1]), 32'h0);
      if (i == 7) chk("t4_done0", 32'(done), 32'h1);
      if (i != 8) tick;
    end
    tick;
    @(negedge clk); chk("t4_gnt1", 32'(gnt), 32'h2);
    tick; req = 2'b00;
    tick; tick;

    // Warm-up read leaves the pointer on port 1
    req = 2'b01; addr0 = 8'h10; len0 = 4'd0;
    tick; req = 2'b00;
    tick; tick;
    // Write burst aborted by reset in beat 2
    req = 2'b01; we = 2'b01; addr0 = 8'h40; len0 = 4'd7; wd0 = 8'hC0;
    tick; req = 2'b00;
    tick; wd0 = 8'hC1;
    tick; wd0 = 8'hC2;
    rst = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'h0);
    chk("t5_async_ack", 32'(ack), 32'h0);
    chk("t5_async_we", 32'(mem_we), 32'h0);
    chk("t5_async_a", 32'(mem_a), 32'h0);
    chk("t5_async_wd", 32'(mem_wd), 32'h0);
    chk("t5_async_rd", 32'(rd), 32'h0);
    tick; tick;
    rst = 1'b1; req = 2'b11; we = 2'b00;
    addr0 = 8'h70; addr1 = 8'h71; len0 = 4'd0; len1 = 4'd0;
    tick;
    @(negedge clk); chk("t5_ptr_port0", 32'(gnt), 32'h1);
    tick; req = 2'b00;
    tick; tick;
    chk("t5_ram_40", 32'(ram[8'h40]), 32'hC0);
    chk("t5_ram_41", 32'(ram[8'h41]), 32'hC1);
    chk("t5_ram_42", 32'(ram[8'h42]), 32'h18);

    // Port 0 drops req on its first ack; burst still completes
    req = 2'b01; we = 2'b00; addr0 = 8'hFE; len0 = 4'd2;
    n_ack = 0; n_rv = 0; n_done = 0;
    tick; req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[0]) n_ack++;
      if (rvalid[0]) begin
        if (n_rv < 3) got[n_rv] = rd;
        n_rv++;
      end
      if (done[0]) n_done++;
      tick;
    end
    chk("t6_acks", 32'(n_ack), 32'd3);
    chk("t6_rvalids", 32'(n_rv), 32'd3);
    chk("t6_done", 32'(n_done), 32'd1);
    chk("t6_rd0", 32'(got[0]), 32'h11);
    chk("t6_rd1", 32'(got[1]), 32'h22);
    chk("t6_rd2", 32'(got[2]), 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
